udp_rx_chan_demux: RTL and testbench
====================================

Name: udp_rx_chan_demux

Overview:
- Parametrised successor to the single-stream UDP receive path.
- Takes the UDP byte stream from the IP receive layer (header plus payload), parses the 8-byte UDP header and steers each datagram to one of CHANNELS logical video channels by destination port.
- Stores each accepted payload in a packet buffer and presents it to the channel consumer with a valid/ack handshake.
- Drops malformed, errored, unmatched or overflowing datagrams and counts them.

Parameters:
- CHANNELS, 4, number of logical channels (1..16).
- BASE_PORT, 16'd8080, destination port of channel 0; channel k listens on BASE_PORT+k.
- BUF_AW, 11, payload buffer address width; capacity is 2^BUF_AW bytes.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_sof  input  1  with in_valid: first UDP header byte.
- in_last  input  1  with in_valid: final byte of the IP payload.
- in_error  input  1  sampled with in_last: MAC CRC, IP checksum or IP address error for this datagram.
- in_data  input  8  stream byte.
- chan_en  input  CHANNELS  per-channel accept mask.
- pkt_valid  output  1  a complete datagram is buffered.
- pkt_chan  output  4  channel index of the buffered datagram.
- pkt_len  output  BUF_AW+1  payload byte count.
- pkt_src_port  output  16  UDP source port.
- pkt_ack  input  1  consumer releases the buffer.
- rd_addr  input  BUF_AW  payload read address.
- rd_data  output  8  payload byte; 1-cycle read latency.
- drop_cnt  output  16  saturating count of dropped datagrams.

Behaviour:
- Reset values: pkt_valid=0, pkt_chan=0, pkt_len=0, pkt_src_port=0, drop_cnt=0, rd_data=0, FSM=IDLE. Reset mid-packet discards the packet; buffer contents become don't-care.
- FSM states:
  - IDLE: in_valid&in_sof -> HDR, with byte 0 captured.
  - HDR: captures bytes 0-7 big-endian (src port, dst port, length, checksum). The checksum is ignored. After byte 7, run the checks:
    - ch = dst_port - BASE_PORT (16-bit);
    - accept iff ch < CHANNELS, chan_en[ch]=1, 8 <= length, and length-8 <= 2^BUF_AW.
    - Accept -> PAY; any failed check -> DROP.
  - PAY: writes each payload byte to address wr_ptr (starting at 0) until length-8 bytes are written. Bytes past that count (Ethernet padding) are ignored. At in_last:
    - error-free and the full count received -> HOLD;
    - otherwise -> IDLE with drop.
    - If length=8 (empty payload), the HDR byte 7 check leads to the in_last handling directly.
  - DROP: consumes bytes until in_last, then returns to IDLE. drop_cnt is incremented once per datagram.
  - HOLD: pkt_valid=1, and pkt_chan/pkt_len/pkt_src_port are stable. pkt_ack (only meaningful while pkt_valid) clears pkt_valid on the next edge -> IDLE.
- Truncation: in_last in HDR before byte 7 -> drop and return to IDLE.
- New in_sof in HDR/PAY/DROP: the current datagram is dropped (counted), and parsing restarts with this byte as header byte 0.
- Datagram arriving in HOLD: the whole datagram is dropped and counted; the buffer is not written. If pkt_ack and in_sof occur in the same cycle, the incoming datagram is dropped.
- drop_cnt saturates at 16'hFFFF. At most one increment per cycle; a drop and an in_sof restart in the same cycle count once.
- in_valid=0 cycles are stalls in any state. Flags are ignored when in_valid=0.
- Buffer: simple dual-port RAM, write port driven by the FSM, read port driven by rd_addr, rd_data registered. Reading while not pkt_valid returns stale data and is legal.
- Ordering guarantee: pkt_valid is never asserted before the last payload byte's write has completed.

Test Plan:
- Accept: BASE_PORT=8080, chan_en=4'hF; send dst port 8082, length 16, payload 01..08, in_error=0 -> pkt_valid=1, pkt_chan=2, pkt_len=8; rd_addr 0..7 returns 01..08 one cycle later; pkt_ack -> pkt_valid=0 next cycle.
- Filtering: send dst port 8084, then dst port 8081 with chan_en=4'b1101 -> no pkt_valid, drop_cnt=2.
- Error/padding: length 12 plus 14 padding bytes with in_error=0 -> pkt_len=4, padding not stored. Same frame with in_error=1 at in_last -> dropped, drop_cnt+1.
- Back-pressure: send two datagrams without ack -> first held unchanged, second dropped, drop_cnt=1. Ack, then send a third datagram -> accepted.
- Boundaries: payload exactly 2^BUF_AW bytes -> accepted, pkt_len=2048. Payload 2049 bytes -> dropped. length=8 -> pkt_valid with pkt_len=0. length=7 -> dropped.
- Abort/reset: in_sof mid-payload -> old datagram dropped (count+1), new one parsed correctly. Assert rst_n=0 during PAY -> all outputs return to reset values, and the next datagram is accepted normally.

Source files
------------

// File: rtl/udp_rx_chan_demux_if.sv
// Stream input and buffered-packet output bundle of the UDP receive channel demux.
// master = upstream source / packet consumer side, slave = the demux itself.
interface udp_rx_chan_demux_if #(
  parameter int BUF_AW = 11
);
  logic              in_valid;
  logic              in_sof;
  logic              in_last;
  logic              in_error;
  logic [7:0]        in_data;
  logic              pkt_valid;
  logic [3:0]        pkt_chan;
  logic [BUF_AW:0]   pkt_len;
  logic [15:0]       pkt_src_port;
  logic              pkt_ack;
  logic [BUF_AW-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (
    output in_valid, in_sof, in_last, in_error, in_data, pkt_ack, rd_addr,
    input  pkt_valid, pkt_chan, pkt_len, pkt_src_port, rd_data
  );

  modport slave (
    input  in_valid, in_sof, in_last, in_error, in_data, pkt_ack, rd_addr,
    output pkt_valid, pkt_chan, pkt_len, pkt_src_port, rd_data
  );
endinterface

// File: rtl/udp_rx_chan_demux.sv
// UDP receive demux: parses the 8-byte header, steers datagrams to channels by
// destination port, buffers one payload at a time and counts dropped datagrams.
module udp_rx_chan_demux #(
  parameter int          CHANNELS  = 4,
  parameter logic [15:0] BASE_PORT = 16'd8080,
  parameter int          BUF_AW    = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  udp_rx_chan_demux_if.slave  bus,
  input  logic [CHANNELS-1:0] chan_en,
  output logic [15:0]         drop_cnt
);
  localparam int LW        = BUF_AW + 1;
  localparam int BUF_BYTES = 1 << BUF_AW;

  typedef enum logic [2:0] {IDLE, HDR, PAY, DROP, HOLD} state_t;

  state_t          state_reg;
  logic [2:0]      hdr_cnt_reg;
  logic [15:0]     src_port_reg, dst_port_reg, len_reg;
  logic [LW-1:0]   wr_ptr_reg, pay_len_reg;
  logic            hold_busy_reg, hold_busy_next;
  logic [15:0]     drop_cnt_reg;
  logic            pkt_valid_reg;
  logic [3:0]      pkt_chan_reg;
  logic [LW-1:0]   pkt_len_reg;
  logic [15:0]     pkt_src_port_reg;
  logic [7:0]      rd_data_reg;
  logic [7:0]      mem [BUF_BYTES];

  logic [15:0]   ch, en_ext;
  logic [LW-1:0] hdr_pay_len;
  logic          sof, last, hdr_done, hdr_ok, hdr_empty_ok, wr_room, pay_full, wr_en, drop_now;

  assign sof          = bus.in_valid && bus.in_sof;
  assign last         = bus.in_valid && bus.in_last;
  assign ch           = dst_port_reg - BASE_PORT;
  assign en_ext       = 16'(chan_en);
  assign hdr_done     = (hdr_cnt_reg == 3'd7);
  assign hdr_pay_len  = LW'(len_reg - 16'd8);
  assign hdr_ok       = (ch < 16'(CHANNELS)) && en_ext[ch[3:0]] && (len_reg >= 16'd8) &&
                        (({1'b0, len_reg} - 17'd8) <= 17'(BUF_BYTES));
  assign hdr_empty_ok = hdr_ok && (hdr_pay_len == '0) && !bus.in_error;
  assign wr_room      = (wr_ptr_reg < pay_len_reg);
  // Padding bytes past the declared length count as neither data nor shortfall.
  assign pay_full     = ((wr_ptr_reg + LW'(wr_room)) == pay_len_reg);
  assign wr_en        = bus.in_valid && !bus.in_sof && (state_reg == PAY) && wr_room;

  always_comb begin
    drop_now       = 1'b0;
    hold_busy_next = hold_busy_reg;
    if (sof) hold_busy_next = 1'b1;
    if (last) hold_busy_next = 1'b0;
    if (bus.in_valid) begin
      unique case (state_reg)
        IDLE: drop_now = sof && last;
        HDR:  drop_now = sof || (last && !(hdr_done && hdr_empty_ok));
        PAY:  drop_now = sof || (last && !(!bus.in_error && pay_full));
        DROP: drop_now = sof || last;
        HOLD: drop_now = (sof && hold_busy_reg) || (last && (hold_busy_reg || sof));
        default: drop_now = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[BUF_AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_reg <= '0;
    else        rd_data_reg <= mem[bus.rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      hdr_cnt_reg      <= '0;
      src_port_reg     <= '0;
      dst_port_reg     <= '0;
      len_reg          <= '0;
      wr_ptr_reg       <= '0;
      pay_len_reg      <= '0;
      hold_busy_reg    <= 1'b0;
      drop_cnt_reg     <= '0;
      pkt_valid_reg    <= 1'b0;
      pkt_chan_reg     <= '0;
      pkt_len_reg      <= '0;
      pkt_src_port_reg <= '0;
    end else begin
      if (drop_now && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      // A start-of-frame outside HOLD always restarts header parsing.
      if (sof && state_reg != HOLD) begin
        src_port_reg[15:8] <= bus.in_data;
        hdr_cnt_reg        <= 3'd1;
        state_reg          <= bus.in_last ? IDLE : HDR;
      end else begin
        unique case (state_reg)
          IDLE: ;
          HDR: if (bus.in_valid) begin
            unique case (hdr_cnt_reg)
              3'd1: src_port_reg[7:0]  <= bus.in_data;
              3'd2: dst_port_reg[15:8] <= bus.in_data;
              3'd3: dst_port_reg[7:0]  <= bus.in_data;
              3'd4: len_reg[15:8]      <= bus.in_data;
              3'd5: len_reg[7:0]       <= bus.in_data;
              default: ;
            endcase
            hdr_cnt_reg <= hdr_cnt_reg + 3'd1;
            if (hdr_done) begin
              pay_len_reg <= hdr_pay_len;
              wr_ptr_reg  <= '0;
              if (bus.in_last) begin
                if (hdr_empty_ok) begin
                  state_reg        <= HOLD;
                  pkt_valid_reg    <= 1'b1;
                  pkt_chan_reg     <= ch[3:0];
                  pkt_len_reg      <= hdr_pay_len;
                  pkt_src_port_reg <= src_port_reg;
                end else begin
                  state_reg <= IDLE;
                end
              end else begin
                state_reg <= hdr_ok ? PAY : DROP;
              end
            end else if (bus.in_last) begin
              state_reg <= IDLE;
            end
          end
          PAY: if (bus.in_valid) begin
            if (wr_room) wr_ptr_reg <= wr_ptr_reg + LW'(1);
            if (bus.in_last) begin
              if (!bus.in_error && pay_full) begin
                state_reg        <= HOLD;
                pkt_valid_reg    <= 1'b1;
                pkt_chan_reg     <= ch[3:0];
                pkt_len_reg      <= pay_len_reg;
                pkt_src_port_reg <= src_port_reg;
              end else begin
                state_reg <= IDLE;
              end
            end
          end
          DROP: if (last) state_reg <= IDLE;
          HOLD: begin
            // A datagram that started while held keeps being discarded after release.
            if (bus.pkt_ack) begin
              pkt_valid_reg <= 1'b0;
              hold_busy_reg <= 1'b0;
              state_reg     <= hold_busy_next ? DROP : IDLE;
            end else begin
              hold_busy_reg <= hold_busy_next;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.pkt_valid    = pkt_valid_reg;
  assign bus.pkt_chan     = pkt_chan_reg;
  assign bus.pkt_len      = pkt_len_reg;
  assign bus.pkt_src_port = pkt_src_port_reg;
  assign bus.rd_data      = rd_data_reg;
  assign drop_cnt         = drop_cnt_reg;
endmodule

// File: tb/tb_udp_rx_chan_demux.sv
// Directed and randomized datagrams checked against a datagram-level reference model.
module tb_udp_rx_chan_demux;
  localparam int          CH   = 4;
  localparam logic [15:0] BASE = 16'd8080;
  localparam int          AW   = 11;
  localparam int          BUFB = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] chan_en;
  logic [15:0]   drop_cnt;

  udp_rx_chan_demux_if #(.BUF_AW(AW)) bus();

  udp_rx_chan_demux #(.CHANNELS(CH), .BASE_PORT(BASE), .BUF_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .chan_en(chan_en), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  tx_pay [0:4095];
  logic [7:0]  exp_pay [0:BUFB-1];
  bit          exp_valid = 1'b0;
  int          exp_chan = 0, exp_len = 0, exp_drop = 0;
  logic [15:0] exp_src = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) tx_pay[i] = 8'($urandom);
  endtask

  // Outcome of one datagram derived from the receive rules, not from the RTL.
  function automatic void model(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                                input int pay_n, input bit err, input bit complete, input int hdr_n,
                                input bit ack_sof);
    logic [15:0] ch;
    bit holding, ok;
    ch = dst - BASE;
    holding = exp_valid;
    if (ack_sof) exp_valid = 1'b0;
    ok = !holding && complete && (hdr_n == 8) && (ch < CH) && (((32'(chan_en) >> ch) & 1) == 1) &&
         (len >= 8) && (int'(len) - 8 <= BUFB) && (pay_n >= int'(len) - 8) && !err;
    if (ok) begin
      exp_valid = 1'b1;
      exp_chan  = int'(ch);
      exp_len   = int'(len) - 8;
      exp_src   = src;
      for (int i = 0; i < exp_len; i++) exp_pay[i] = tx_pay[i];
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endfunction

  task automatic send(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                      input int pay_n, input bit err, input bit complete, input int hdr_n,
                      input bit ack_sof, input int stall_pct);
    logic [7:0]  q[$];
    logic [15:0] cks;
    cks = 16'($urandom);
    q.push_back(src[15:8]); q.push_back(src[7:0]);
    q.push_back(dst[15:8]); q.push_back(dst[7:0]);
    q.push_back(len[15:8]); q.push_back(len[7:0]);
    q.push_back(cks[15:8]); q.push_back(cks[7:0]);
    while (q.size() > hdr_n) void'(q.pop_back());
    if (hdr_n == 8) for (int i = 0; i < pay_n; i++) q.push_back(tx_pay[i]);
    for (int i = 0; i < q.size(); i++) begin
      if (int'($urandom_range(99)) < stall_pct) begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'($urandom);
        bus.in_last  = 1'($urandom);
        bus.in_error = 1'($urandom);
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_sof   = (i == 0);
      bus.in_last  = complete && (i == q.size() - 1);
      bus.in_error = (i == q.size() - 1) ? err : 1'($urandom);
      bus.in_data  = q[i];
      bus.pkt_ack  = ack_sof && (i == 0);
      @(negedge clk);
      bus.pkt_ack  = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_error = 1'b0;
    model(src, dst, len, pay_n, err, complete, hdr_n, ack_sof);
  endtask

  task automatic check_state(input string tag, input bit read_all);
    int n, bad, a;
    $display("[TB] %s: pkt_valid=%0d chan=%0d len=%0d drop_cnt=%0d (model valid=%0d len=%0d drop=%0d)",
             tag, bus.pkt_valid, bus.pkt_chan, bus.pkt_len, drop_cnt, exp_valid, exp_len, exp_drop);
    check({tag, ".pkt_valid"}, 32'(bus.pkt_valid), 32'(exp_valid));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    if (exp_valid) begin
      check({tag, ".pkt_chan"}, 32'(bus.pkt_chan), 32'(exp_chan));
      check({tag, ".pkt_len"}, 32'(bus.pkt_len), 32'(exp_len));
      check({tag, ".pkt_src_port"}, 32'(bus.pkt_src_port), 32'(exp_src));
      n = read_all ? exp_len : ((exp_len < 12) ? exp_len : 12);
      bad = 0;
      for (int k = 0; k < n; k++) begin
        a = read_all ? k : int'($urandom_range(exp_len - 1));
        bus.rd_addr = AW'(a);
        @(negedge clk);
        if (bus.rd_data !== exp_pay[a]) bad++;
      end
      check({tag, ".payload_errors"}, 32'(bad), 32'd0);
    end
  endtask

  task automatic ack(input string tag);
    bus.pkt_ack = 1'b1;
    @(negedge clk);
    bus.pkt_ack = 1'b0;
    exp_valid = 1'b0;
    check({tag, ".after_ack"}, 32'(bus.pkt_valid), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
    check({tag, ".pkt_chan"}, 32'(bus.pkt_chan), 32'd0);
    check({tag, ".pkt_len"}, 32'(bus.pkt_len), 32'd0);
    check({tag, ".pkt_src_port"}, 32'(bus.pkt_src_port), 32'd0);
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'd0);
    check({tag, ".rd_data"}, 32'(bus.rd_data), 32'd0);
  endtask

  initial begin
    int pay_n, bad;
    logic [15:0] len, dst;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_last = 1'b0; bus.in_error = 1'b0;
    bus.in_data = '0; bus.pkt_ack = 1'b0; bus.rd_addr = '0;
    chan_en = 4'hF;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Accept on channel 2 with a known payload.
    for (int i = 0; i < 8; i++) tx_pay[i] = 8'(i + 1);
    send(16'h1234, 16'd8082, 16'd16, 8, 0, 1, 8, 0, 0);
    check_state("accept", 1);
    check("accept.chan_is_2", 32'(bus.pkt_chan), 32'd2);
    ack("accept");

    // Port filtering: out of range, then disabled channel.
    fill_random(8);
    send(16'h0001, 16'd8084, 16'd16, 8, 0, 1, 8, 0, 10);
    chan_en = 4'b1101;
    send(16'h0002, 16'd8081, 16'd16, 8, 0, 1, 8, 0, 10);
    check_state("filter", 0);
    check("filter.drop_is_2", 32'(drop_cnt), 32'd2);
    chan_en = 4'hF;

    // Padding beyond the declared length must not reach the buffer.
    for (int i = 0; i < 4; i++) tx_pay[i] = 8'hC0 + 8'(i);
    for (int i = 4; i < 18; i++) tx_pay[i] = 8'hA5;
    send(16'h0BAD, 16'd8080, 16'd12, 18, 0, 1, 8, 0, 0);
    check_state("padding", 1);
    bad = 0;
    for (int a = 4; a < 8; a++) begin
      bus.rd_addr = AW'(a);
      @(negedge clk);
      if (bus.rd_data !== 8'(a + 1)) bad++;
    end
    check("padding.not_stored", 32'(bad), 32'd0);
    ack("padding");
    send(16'h0BAD, 16'd8080, 16'd12, 18, 1, 1, 8, 0, 0);
    check_state("error_frame", 0);

    // Back-pressure: second datagram dropped while the first is held.
    fill_random(10);
    send(16'h1111, 16'd8081, 16'd18, 10, 0, 1, 8, 0, 15);
    fill_random(10);
    send(16'h2222, 16'd8083, 16'd18, 10, 0, 1, 8, 0, 15);
    check_state("held", 1);
    ack("held");
    fill_random(6);
    send(16'h3333, 16'd8083, 16'd14, 6, 0, 1, 8, 0, 15);
    check_state("third", 1);
    fill_random(5);
    send(16'h4444, 16'd8080, 16'd13, 5, 0, 1, 8, 1, 0);
    check_state("ack_with_sof", 0);

    // Buffer-size and length boundaries.
    fill_random(2048);
    send(16'h5555, 16'd8081, 16'd2056, 2048, 0, 1, 8, 0, 0);
    check_state("max_payload", 1);
    ack("max_payload");
    fill_random(2049);
    send(16'h5556, 16'd8081, 16'd2057, 2049, 0, 1, 8, 0, 0);
    check_state("oversize", 0);
    send(16'h6666, 16'd8082, 16'd8, 0, 0, 1, 8, 0, 0);
    check_state("empty", 0);
    ack("empty");
    send(16'h6667, 16'd8082, 16'd8, 6, 0, 1, 8, 0, 10);
    check_state("empty_padded", 0);
    ack("empty_padded");
    send(16'h7777, 16'd8082, 16'd7, 0, 0, 1, 8, 0, 0);
    check_state("len7", 0);
    send(16'h7778, 16'd8082, 16'd16, 0, 0, 1, 5, 0, 0);
    check_state("truncated_hdr", 0);

    // New start-of-frame in the middle of a payload.
    fill_random(10);
    send(16'h8888, 16'd8080, 16'd28, 10, 0, 0, 8, 0, 0);
    fill_random(6);
    send(16'h9999, 16'd8083, 16'd14, 6, 0, 1, 8, 0, 10);
    check_state("abort", 1);
    ack("abort");

    // Asynchronous reset while a payload is arriving.
    fill_random(5);
    send(16'hAAAA, 16'd8081, 16'd28, 5, 0, 0, 8, 0, 0);
    rst_n = 1'b0;
    #2;
    check_reset("mid_reset");
    exp_valid = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random(9);
    send(16'hBBBB, 16'd8082, 16'd17, 9, 0, 1, 8, 0, 10);
    check_state("after_reset", 1);
    ack("after_reset");

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      chan_en = ($urandom_range(3) == 0) ? CH'($urandom) : 4'hF;
      dst = BASE - 16'd2 + 16'($urandom_range(7));
      pay_n = int'($urandom_range(40));
      if ($urandom_range(3) != 0) len = 16'(8 + pay_n - int'($urandom_range((pay_n < 3) ? pay_n : 3)));
      else len = 16'($urandom_range(60));
      fill_random(pay_n);
      send(16'($urandom), dst, len, pay_n, ($urandom_range(7) == 0), 1,
           ($urandom_range(9) == 0) ? int'($urandom_range(1, 7)) : 8,
           exp_valid && ($urandom_range(5) == 0), 20);
      check_state($sformatf("rand%0d", t), 0);
      if (exp_valid && $urandom_range(2) != 0) ack($sformatf("rand%0d", t));
    end
    if (exp_valid) ack("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
